// File: rtl/fetch_coalescer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_coalescer
// Purpose  : Arbitrates fetchers onto one program-memory channel and serves
//            every fetcher waiting on the same address with a single read.
// Revision : 1.0  initial release
// ============================================================================
module fetch_coalescer #(
  parameter int NUM_CONSUMERS = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data    [NUM_CONSUMERS],
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,
  output logic [7:0]               coalesced_count
);

  localparam int PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_READ_WAIT = 2'd1;
  localparam logic [1:0] S_RELAY     = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_next_state;
  logic [PTR_BITS-1:0]      r_rr_ptr;
  logic [PTR_BITS-1:0]      r_winner;
  logic [NUM_CONSUMERS-1:0] r_serve_mask;

  logic                     w_found;
  logic [PTR_BITS-1:0]      w_winner;
  logic [ADDR_BITS-1:0]     w_win_addr;
  logic [ADDR_BITS-1:0]     w_cmp_addr;
  logic [NUM_CONSUMERS-1:0] w_match;
  logic [NUM_CONSUMERS-1:0] w_done_mask;
  logic [3:0]               w_pop;
  logic [8:0]               w_sum;

  logic                     w_nxt_mem_valid;
  logic [ADDR_BITS-1:0]     w_nxt_mem_addr;
  logic [NUM_CONSUMERS-1:0] w_nxt_ready;
  logic [NUM_CONSUMERS-1:0] w_nxt_mask;
  logic [PTR_BITS-1:0]      w_nxt_winner;
  logic [PTR_BITS-1:0]      w_nxt_ptr;
  logic [7:0]               w_nxt_count;

  // Round-robin search starting at r_rr_ptr, wrapping past the last fetcher.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (!w_found &&
          consumer_read_valid[PTR_BITS'((int'(r_rr_ptr) + k) % NUM_CONSUMERS)]) begin
        w_found  = 1'b1;
        w_winner = PTR_BITS'((int'(r_rr_ptr) + k) % NUM_CONSUMERS);
      end
    end
  end

  assign w_win_addr = consumer_read_address[w_winner];
  // In IDLE compare against the new winner; afterwards against the in-flight address.
  assign w_cmp_addr = (r_state == S_IDLE) ? w_win_addr : mem_read_address;

  generate
    for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_match
      assign w_match[gi] = consumer_read_valid[gi] &&
                           (consumer_read_address[gi] == w_cmp_addr);
    end
  endgenerate

  assign w_done_mask = r_serve_mask | w_match;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      w_pop = w_pop + {3'b000, w_done_mask[i]};
    end
  end

  // The winner is always in the mask, so w_pop >= 1 and the subtraction never underflows.
  assign w_sum = {1'b0, coalesced_count} + {5'b00000, w_pop} - 9'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state             <= S_IDLE;
      r_rr_ptr            <= '0;
      r_winner            <= '0;
      r_serve_mask        <= '0;
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      coalesced_count     <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        consumer_read_data[i] <= '0;
      end
    end else begin
      r_state             <= w_next_state;
      r_rr_ptr            <= w_nxt_ptr;
      r_winner            <= w_nxt_winner;
      r_serve_mask        <= w_nxt_mask;
      mem_read_valid      <= w_nxt_mem_valid;
      mem_read_address    <= w_nxt_mem_addr;
      consumer_read_ready <= w_nxt_ready;
      coalesced_count     <= w_nxt_count;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        if (w_nxt_ready[i]) begin
          consumer_read_data[i] <= mem_read_data;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_found)        w_next_state = S_READ_WAIT;
      S_READ_WAIT: if (mem_read_ready) w_next_state = S_RELAY;
      S_RELAY: begin
        if ((consumer_read_valid & r_serve_mask) == '0) w_next_state = S_IDLE;
      end
      default:                         w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_nxt_mem_valid = mem_read_valid;
    w_nxt_mem_addr  = mem_read_address;
    w_nxt_ready     = '0;
    w_nxt_mask      = r_serve_mask;
    w_nxt_winner    = r_winner;
    w_nxt_ptr       = r_rr_ptr;
    w_nxt_count     = coalesced_count;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_nxt_mem_valid = 1'b1;
          w_nxt_mem_addr  = w_win_addr;
          w_nxt_mask      = w_match;
          w_nxt_winner    = w_winner;
        end
      end
      S_READ_WAIT: begin
        w_nxt_mask = w_done_mask;
        if (mem_read_ready) begin
          w_nxt_mem_valid = 1'b0;
          w_nxt_ready     = w_done_mask;
          w_nxt_ptr       = (r_winner == PTR_BITS'(NUM_CONSUMERS - 1)) ?
                            '0 : r_winner + PTR_BITS'(1);
          w_nxt_count     = w_sum[8] ? 8'hFF : w_sum[7:0];
        end
      end
      S_RELAY: begin
        if ((consumer_read_valid & r_serve_mask) == '0) w_nxt_mask = '0;
      end
      default: begin
        w_nxt_mem_valid = 1'b0;
        w_nxt_mask      = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
